// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout, s} <= a + b + c one clock after sampling.
// WIDTH = 1 gives the classic single-bit full adder cell.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  output logic [WIDTH-1:0] s,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             clk,
  input  logic             rst
);

  logic [WIDTH:0]   w_k;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  assign w_k[0] = c;

  // Explicit ripple chain of single-bit cells; w_k[i] is the carry into bit i.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign w_sum[i]  = a[i] ^ b[i] ^ w_k[i];
    assign w_k[i+1]  = (a[i] & b[i]) | (a[i] & w_k[i]) | (b[i] & w_k[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_sum;
      r_cout <= w_k[WIDTH];
    end
  end

  assign s    = r_s;
  assign cout = r_cout;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 4 and 64 against an arithmetic reference.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a1, b1, c1, s1, co1;
  logic [3:0]  a4, b4, s4;
  logic        c4, co4;
  logic [63:0] a64, b64, s64;
  logic        c64, co64;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  full_adder #(.WIDTH(1)) u_dut1 (
    .s(s1), .cout(co1), .a(a1), .b(b1), .c(c1), .clk(clk), .rst(rst)
  );
  full_adder #(.WIDTH(4)) u_dut4 (
    .s(s4), .cout(co4), .a(a4), .b(b4), .c(c4), .clk(clk), .rst(rst)
  );
  full_adder #(.WIDTH(64)) u_dut64 (
    .s(s64), .cout(co64), .a(a64), .b(b64), .c(c64), .clk(clk), .rst(rst)
  );

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {cout,s}=%h expected %h", tag, got, exp);
    end
  endtask

  // Reference: full-precision unsigned sum; the top bit is the carry-out.
  function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic c);
    return {1'b0, a} + {1'b0, b} + {64'd0, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [64:0] got1();
    return {63'd0, co1, s1};
  endfunction

  function automatic logic [64:0] got4();
    return {60'd0, co4, s4};
  endfunction

  initial begin
    logic [2:0] seq [6];
    logic [64:0] exp;

    // Reset held for two edges with all-ones inputs
    {a1, b1, c1} = 3'b111;
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    a64 = '1;  b64 = '1;  c64 = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_w1", got1(), 65'd0);
      check("rst_w4", got4(), 65'd0);
      check("rst_w64", {co64, s64}, 65'd0);
    end
    rst = 1'b0;
    tick();
    check("post_rst_w1", got1(), ref_add(64'd1, 64'd1, 1'b1));
    check("post_rst_w4", got4(), ref_add(64'hF, 64'hF, 1'b1));
    check("post_rst_w64", {co64, s64}, ref_add('1, '1, 1'b1));

    // Exhaustive single-bit
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = 3'(i);
      exp = ref_add({63'd0, a1}, {63'd0, b1}, c1);
      tick();
      check($sformatf("exh1_%0d", i), got1(), exp);
    end

    // Back-to-back changes, one per edge
    seq[0] = 3'b111; seq[1] = 3'b110; seq[2] = 3'b111;
    seq[3] = 3'b100; seq[4] = 3'b101; seq[5] = 3'b010;
    for (int i = 0; i < 6; i++) begin
      {a1, b1, c1} = seq[i];
      exp = ref_add({63'd0, a1}, {63'd0, b1}, c1);
      tick();
      check($sformatf("b2b_%0d", i), got1(), exp);
    end

    // Mid-stream reset for a single edge
    {a1, b1, c1} = 3'b111;
    tick();
    check("stream_pre", got1(), 65'b11);
    rst = 1'b1;
    tick();
    check("stream_rst", got1(), 65'd0);
    rst = 1'b0;
    tick();
    check("stream_post", got1(), 65'b11);

    // WIDTH=4 boundaries
    a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    tick();
    check("w4_f_0_1", got4(), {60'd0, 1'b1, 4'h0});
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    tick();
    check("w4_f_f_1", got4(), {60'd0, 1'b1, 4'hF});
    a4 = 4'h5; b4 = 4'hA; c4 = 1'b0;
    tick();
    check("w4_5_a_0", got4(), {60'd0, 1'b0, 4'hF});

    // Random WIDTH=4 and WIDTH=64 streams, compared one cycle later
    for (int i = 0; i < 1000; i++) begin
      logic [64:0] exp64;
      a4  = 4'($urandom);
      b4  = 4'($urandom);
      c4  = 1'($urandom);
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      c64 = 1'($urandom);
      if (i % 50 == 0) begin
        a64 = '1;
        b64 = 64'd0;
        c64 = 1'b1;
      end
      exp   = ref_add({60'd0, a4}, {60'd0, b4}, c4);
      exp64 = ref_add(a64, b64, c64);
      tick();
      check("rand_w4", got4(), exp);
      check("rand_w64", {co64, s64}, exp64);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
